iot_byte_assembler: RTL and testbench
=====================================

// Module: iot_byte_assembler
// PURPOSE
//  Front end of the IoT data-filter datapath: takes the 8-bit serial sensor stream (16 bytes per datum)
//  and assembles each 128-bit word. Publishes the word together with the cnt_cycle phase count that the
//  downstream filter functions use to qualify a complete word (they evaluate at cnt_cycle==1).
//  Drives busy back to the stream source and honours a stall from the function stage.
// PARAMETERS
//  NBYTE   16  bytes per datum; data width = 8*NBYTE (128)
//  WCNT_W  7   width of published-word counter (optional feature only)
// PORTS
//  clk        in   1    system clock, rising edge
//  rst        in   1    reset, asynchronous, active-high
//  in_en      in   1    iot_in carries a valid byte this cycle
//  iot_in     in   8    serial byte, most-significant byte of the datum first
//  stall      in   1    downstream cannot take the published word this cycle
//  busy       out  1    assembler cannot accept a byte this cycle
//  data       out  128  last completed word
//  data_vld   out  1    data holds a published, not-yet-consumed word
//  cnt_cycle  out  4    phase count since publish; ==1 in the first publish cycle
//  wcnt       out  WCNT_W  published-word count (only with IOT_ASM_WCNT_EN)
// BEHAVIOUR
//  - Reset (async, any time incl. mid-word): bcnt=0, shift reg=0, data=0, data_vld=0, cnt_cycle=0, busy=0;
//    a partially received word is discarded. First edge after release behaves as idle.
//  - Byte accept: in_en && !busy at the rising edge. Bytes offered while busy=1 are ignored
//    (not shifted, not counted). The source must hold the byte until it is accepted.
//  - Accept with bcnt<NBYTE-1: sreg <= {sreg[119:0], iot_in}; bcnt <= bcnt+1.
//  - Accept with bcnt==NBYTE-1 (word completes): data <= {sreg[119:0], iot_in}; data_vld <= 1;
//    cnt_cycle <= 1; bcnt <= 0. Latency: data valid the cycle after the 16th byte is accepted.
//  - Consume: a word is consumed in any cycle with data_vld && !stall.
//    data_vld clears the next cycle unless a new word completes on the same edge, in which case it stays 1.
//    data is not cleared on consume; it holds its last value.
//  - cnt_cycle: loads 1 on completion. Otherwise, if nonzero and !(data_vld && stall), it increments,
//    wrapping 15->0, and then stays 0. It holds while data_vld && stall.
//  - busy = (bcnt==NBYTE-1) && data_vld. This is a decode of registered state only; there is no
//    combinational path from stall. While a word is pending, bytes 1..15 of the next word are still taken.
//    Only byte 16 is blocked, so no pending word is ever overwritten.
//  - Simultaneous events: consume and completion on the same edge -> the new word is published and
//    data_vld stays 1. If busy=1 and stall drops in cycle N, the word is consumed at edge N,
//    busy=0 in cycle N+1, and the 16th byte is accepted at edge N+1.
//  - in_en with rst=1: ignored.
// CONFIGURATION
//  IOT_ASM_WCNT_EN defined:
//    - wcnt port exists, reset 0.
//    - Increments on each completion edge; wraps at 2^WCNT_W.
//  IOT_ASM_WCNT_EN undefined:
//    - wcnt port and counter logic are absent; all other behaviour is identical.
// TESTING
//  1 Reset: rst=1 mid-run -> data=0, data_vld=0, busy=0, cnt_cycle=0 immediately (asynchronous).
//  2 Bytes 00..0F on 16 consecutive cycles, stall=0 -> next cycle: data=128'h000102030405060708090A0B0C0D0E0F,
//    data_vld=1 for 1 cycle, cnt_cycle=1,2,...,15,0.
//  3 Back-to-back words A (bytes 10..1F) then B (bytes 20..2F), in_en always 1, stall=0
//    -> data_vld pulses 16 cycles apart, data=A then B, busy stays 0.
//  4 stall=1 after word A publishes; feed word B -> 15 bytes accepted, busy=1, byte 16 held and ignored,
//    data=A and cnt_cycle=1 held. Drop stall -> busy=0 next cycle, byte 16 accepted, data=B, cnt_cycle=1.
//  5 in_en every other cycle with bytes FF,EE,...,00 -> data=128'hFFEEDDCCBBAA99887766554433221100
//    one cycle after the last byte.
//  6 rst pulse after 8 bytes, then 16 bytes 0x5A -> data=all 0x5A, no leftover bytes.
//    With IOT_ASM_WCNT_EN, wcnt=1 after this word (reset cleared the earlier count).

Source files
------------

// File: rtl/iot_byte_assembler.sv
// iot_byte_assembler
// Collects a serial byte stream (most-significant byte first) into NBYTE-byte
// words and publishes each completed word with a valid flag and a phase count.
// Byte 16 of a word is held off with busy while the previous word is still
// unconsumed, so a pending word is never overwritten.
// Optional build macro: IOT_ASM_WCNT_EN adds the wcnt published-word counter.

module iot_byte_assembler #(
    parameter int NBYTE = 16
`ifdef IOT_ASM_WCNT_EN
    ,
    parameter int WCNT_W = 7
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_en,
    input  logic [7:0]           iot_in,
    input  logic                 stall,
`ifdef IOT_ASM_WCNT_EN
    output logic [WCNT_W-1:0]    wcnt,
`endif
    output logic                 busy,
    output logic [8*NBYTE-1:0]   data,
    output logic                 data_vld,
    output logic [3:0]           cnt_cycle
);

    localparam int DW     = 8 * NBYTE;
    localparam int BCNT_W = $clog2(NBYTE);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NBYTE - 1);

    // Only the last NBYTE-1 bytes ever matter: the final byte goes straight
    // into data together with them.
    logic [BCNT_W-1:0] bcnt_r;
    logic [DW-9:0]     sreg_r;

    logic              accept_s;
    logic              complete_s;
    logic              consume_s;
    logic              hold_s;
    logic [DW-1:0]     shifted_s;

    logic [BCNT_W-1:0] bcnt_s;
    logic [DW-9:0]     sreg_s;
    logic [DW-1:0]     data_s;
    logic              data_vld_s;
    logic [3:0]        cnt_cycle_s;
    logic              busy_s;

    assign accept_s   = in_en && !busy;
    assign complete_s = accept_s && (bcnt_r == BCNT_LAST);
    assign consume_s  = data_vld && !stall;
    assign hold_s     = data_vld && stall;
    assign shifted_s  = {sreg_r, iot_in};

    // Next-state computation for byte counter, shift register and output word.
    always_comb begin
        bcnt_s      = bcnt_r;
        sreg_s      = sreg_r;
        data_s      = data;
        data_vld_s  = data_vld;
        cnt_cycle_s = cnt_cycle;
        if (complete_s) begin
            bcnt_s      = {BCNT_W{1'b0}};
            data_s      = shifted_s;
            data_vld_s  = 1'b1;
            cnt_cycle_s = 4'd1;
        end else begin
            if (accept_s) begin
                sreg_s = shifted_s[DW-9:0];
                bcnt_s = bcnt_r + BCNT_W'(1);
            end else begin
                sreg_s = sreg_r;
                bcnt_s = bcnt_r;
            end
            if (consume_s) begin
                data_vld_s = 1'b0;
            end else begin
                data_vld_s = data_vld;
            end
            // Phase count runs once per publish, wraps 15->0 and parks at 0;
            // it freezes while the word is being held back by stall.
            if ((cnt_cycle != 4'd0) && !hold_s) begin
                cnt_cycle_s = cnt_cycle + 4'd1;
            end else begin
                cnt_cycle_s = cnt_cycle;
            end
        end
        // busy depends only on next registered state, so it can be registered
        // itself without any path from stall in the current cycle.
        busy_s = (bcnt_s == BCNT_LAST) && data_vld_s;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt_r    <= {BCNT_W{1'b0}};
            sreg_r    <= {(DW-8){1'b0}};
            data      <= {DW{1'b0}};
            data_vld  <= 1'b0;
            cnt_cycle <= 4'd0;
            busy      <= 1'b0;
        end else begin
            bcnt_r    <= bcnt_s;
            sreg_r    <= sreg_s;
            data      <= data_s;
            data_vld  <= data_vld_s;
            cnt_cycle <= cnt_cycle_s;
            busy      <= busy_s;
        end
    end

`ifdef IOT_ASM_WCNT_EN
    // Published-word counter, free-running with natural wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wcnt <= {WCNT_W{1'b0}};
        end else if (complete_s) begin
            wcnt <= wcnt + WCNT_W'(1);
        end else begin
            wcnt <= wcnt;
        end
    end
`endif

endmodule

// File: tb/tb_iot_byte_assembler.sv
// Self-checking bench for iot_byte_assembler: expected words are queued as
// stimulus is issued and popped whenever the DUT publishes a new word.

module tb_iot_byte_assembler;

    logic         clk;
    logic         rst;
    logic         in_en;
    logic [7:0]   iot_in;
    logic         stall;
    logic         busy;
    logic [127:0] data;
    logic         data_vld;
    logic [3:0]   cnt_cycle;
`ifdef IOT_ASM_WCNT_EN
    logic [6:0]   wcnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int busy_waits = 0;
    logic [127:0] sb_q[$];
    logic prev_vld   = 1'b0;
    logic prev_stall = 1'b0;

    iot_byte_assembler dut (
        .clk       (clk),
        .rst       (rst),
        .in_en     (in_en),
        .iot_in    (iot_in),
        .stall     (stall),
`ifdef IOT_ASM_WCNT_EN
        .wcnt      (wcnt),
`endif
        .busy      (busy),
        .data      (data),
        .data_vld  (data_vld),
        .cnt_cycle (cnt_cycle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Offer one byte and hold it until the DUT accepts it (bounded wait).
    task automatic send_byte(input logic [7:0] b);
        logic acc;
        logic done;
        done   = 1'b0;
        in_en  = 1'b1;
        iot_in = b;
        for (int k = 0; k < 200; k++) begin
            acc = !busy;
            if (!acc) busy_waits++;
            @(posedge clk);
            #1;
            if (acc) begin
                done = 1'b1;
                break;
            end
        end
        check_value("accept_timeout", done, 1'b1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Publish monitor: a new word shows cnt_cycle==1 with data_vld, except in
    // cycles where the previous cycle was already holding a stalled word.
    always @(negedge clk) begin
        logic [127:0] exp;
        if (rst) begin
            prev_vld   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (data_vld && (cnt_cycle == 4'd1) && !(prev_vld && prev_stall)) begin
                if (sb_q.size() > 0) exp = sb_q.pop_front();
                else exp = 'x;
                check_value("publish_data", data, exp);
            end
            prev_vld   = data_vld;
            prev_stall = stall;
        end
    end

    initial begin
        logic [127:0] wa;
        logic [127:0] wb;
        rst    = 1'b1;
        in_en  = 1'b1;
        iot_in = 8'hAA;
        stall  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_value("rst_data", data, 128'h0);
        check_value("rst_vld", data_vld, 1'b0);
        check_value("rst_busy", busy, 1'b0);
        check_value("rst_cnt", cnt_cycle, 4'd0);
        rst   = 1'b0;
        in_en = 1'b0;
        tick();

        // Single word 00..0F, then the full cnt_cycle sequence.
        sb_q.push_back(128'h000102030405060708090A0B0C0D0E0F);
        for (int i = 0; i < 16; i++) send_byte(8'(i));
        in_en = 1'b0;
        check_value("t2_data", data, 128'h000102030405060708090A0B0C0D0E0F);
        check_value("t2_vld", data_vld, 1'b1);
        check_value("t2_cnt1", cnt_cycle, 4'd1);
        for (int i = 2; i <= 17; i++) begin
            tick();
            check_value("t2_cnt", cnt_cycle, (i >= 16) ? 4'd0 : 4'(i));
            check_value("t2_vld_low", data_vld, 1'b0);
        end

        // Back-to-back words with in_en held high.
        wa = '0;
        wb = '0;
        for (int i = 0; i < 16; i++) begin
            wa = {wa[119:0], 8'(8'h10 + i)};
            wb = {wb[119:0], 8'(8'h20 + i)};
        end
        sb_q.push_back(wa);
        sb_q.push_back(wb);
        busy_waits = 0;
        for (int i = 0; i < 32; i++) begin
            send_byte(8'(8'h10 + i));
            if (i == 15) begin
                check_value("t3_a_data", data, wa);
                check_value("t3_a_vld", data_vld, 1'b1);
            end
            if (i == 16) check_value("t3_a_vld_pulse", data_vld, 1'b0);
        end
        in_en = 1'b0;
        check_value("t3_b_data", data, wb);
        check_value("t3_b_vld", data_vld, 1'b1);
        check_value("t3_no_busy", busy_waits, 0);
        repeat (20) tick();

        // Stall holds word A; byte 16 of B is blocked until stall drops.
        wa = '0;
        wb = '0;
        for (int i = 0; i < 16; i++) begin
            wa = {wa[119:0], 8'(8'h30 + i)};
            wb = {wb[119:0], 8'(8'h40 + i)};
        end
        sb_q.push_back(wa);
        sb_q.push_back(wb);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h30 + i));
        stall = 1'b1;
        send_byte(8'h3F);
        in_en = 1'b0;
        check_value("t4_a_vld", data_vld, 1'b1);
        check_value("t4_a_cnt", cnt_cycle, 4'd1);
        for (int i = 0; i < 15; i++) send_byte(8'(8'h40 + i));
        iot_in = 8'h4F;
        check_value("t4_busy", busy, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_value("t4_busy_hold", busy, 1'b1);
            check_value("t4_data_hold", data, wa);
            check_value("t4_cnt_hold", cnt_cycle, 4'd1);
        end
        stall = 1'b0;
        tick();
        check_value("t4_busy_drop", busy, 1'b0);
        check_value("t4_consumed", data_vld, 1'b0);
        tick();
        in_en = 1'b0;
        check_value("t4_b_data", data, wb);
        check_value("t4_b_vld", data_vld, 1'b1);
        check_value("t4_b_cnt", cnt_cycle, 4'd1);
        repeat (4) tick();

        // Bytes FF,EE,...,00 offered every other cycle.
        sb_q.push_back(128'hFFEEDDCCBBAA99887766554433221100);
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(255 - 17 * i));
            if (i < 15) begin
                in_en = 1'b0;
                tick();
            end
        end
        in_en = 1'b0;
        check_value("t5_data", data, 128'hFFEEDDCCBBAA99887766554433221100);
        check_value("t5_vld", data_vld, 1'b1);
        repeat (3) tick();

        // Asynchronous reset mid-word, then a clean word of 0x5A.
        for (int i = 0; i < 8; i++) send_byte(8'h77);
        #2;
        rst = 1'b1;
        #1;
        check_value("t6_rst_data", data, 128'h0);
        check_value("t6_rst_vld", data_vld, 1'b0);
        check_value("t6_rst_busy", busy, 1'b0);
        check_value("t6_rst_cnt", cnt_cycle, 4'd0);
        tick();
        rst   = 1'b0;
        in_en = 1'b0;
        tick();
        sb_q.push_back({16{8'h5A}});
        for (int i = 0; i < 16; i++) send_byte(8'h5A);
        in_en = 1'b0;
        check_value("t6_data", data, {16{8'h5A}});
        check_value("t6_vld", data_vld, 1'b1);
`ifdef IOT_ASM_WCNT_EN
        check_value("t6_wcnt", wcnt, 7'd1);
`endif
        repeat (5) tick();
        check_value("sb_empty", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
